// File: rtl/shu_pipe_if.sv
// Request/result channel of the pipelined shift unit shu_pipe.
// Both directions: a beat transfers on a rising edge where valid && ready; the source holds its payload steady while valid is high and not yet accepted.
interface shu_pipe_if #(
    parameter int N = 32
);
    localparam int K = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [K-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] r;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, r
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, r
    );
endinterface

// File: rtl/shu_pipe.sv
// Two-stage sll/srl/sra shifter; right shifts reuse the left-shift datapath by bit-reversal.
// Define SHU_ROTATE_EN to make op=11 a rotate right; otherwise op=11 behaves as sll.
module shu_pipe #(
    parameter  int N = 32,
    localparam int K = $clog2(N)
) (
    input logic        clk,
    input logic        rst_n,
    shu_pipe_if.slave  bus
);
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
        logic [N-1:0] o;
        for (int i = 0; i < N; i++) o[i] = v[N-1-i];
        return o;
    endfunction

    // Upper half of {x, lo} << amt: lo supplies the bits shifted in at the bottom.
    function automatic logic [N-1:0] shl_fill(input logic [N-1:0] x,
                                              input logic [N-1:0] lo,
                                              input logic [K-1:0] amt);
        logic [2*N-1:0] t;
        t = {x, lo} << amt;
        return t[2*N-1:N];
    endfunction

    function automatic logic is_right(input logic [1:0] op);
        logic res;
        res = (op == OP_SRL) || (op == OP_SRA);
`ifdef SHU_ROTATE_EN
        res = res || (op == OP_ROR);
`endif
        return res;
    endfunction

    logic         s1_valid;
    logic [N-1:0] s1_x;
    logic [K-3:0] s1_bhi;
    logic [1:0]   s1_op;
    logic         s1_f;

    logic         s2_valid;
    logic [N-1:0] r_q;

    logic         s1_adv;
    logic         s2_adv;

    logic         right1;
    logic         f1;
    logic [N-1:0] x0;
    logic [N-1:0] lo1;
    logic [N-1:0] x1;

    logic [N-1:0] lo2;
    logic [N-1:0] y2;
    logic [N-1:0] res2;

    assign s2_adv        = !s2_valid || bus.out_ready;
    assign s1_adv        = !s1_valid || s2_adv;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.r         = r_q;

    // Stage 1: orient the operand and apply the fine (0..3) part of the shift.
    always_comb begin
        right1 = is_right(bus.op);
        x0     = right1 ? bitrev(bus.a) : bus.a;
        f1     = (bus.op == OP_SRA) && bus.a[N-1];
        lo1    = {N{f1}};
`ifdef SHU_ROTATE_EN
        if (bus.op == OP_ROR) lo1 = x0;
`endif
        x1     = shl_fill(x0, lo1, {{(K-2){1'b0}}, bus.b[1:0]});
    end

    // Stage 2: coarse shift by multiples of four, then undo the reversal.
    always_comb begin
        lo2 = {N{s1_f}};
`ifdef SHU_ROTATE_EN
        if (s1_op == OP_ROR) lo2 = s1_x;
`endif
        y2   = shl_fill(s1_x, lo2, {s1_bhi, 2'b00});
        res2 = is_right(s1_op) ? bitrev(y2) : y2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_bhi   <= '0;
            s1_op    <= '0;
            s1_f     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_x   <= x1;
                s1_bhi <= bus.b[K-1:2];
                s1_op  <= bus.op;
                s1_f   <= f1;
            end
        end
    end

    // r only changes when a new result moves in, so it holds across backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            r_q      <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) r_q <= res2;
        end
    end
endmodule

// File: tb/tb_shu_pipe.sv
// Randomised scoreboard bench for shu_pipe: driver pushes expected results, a negedge monitor pops and compares.
// Expected values come from directed constants or a plain-arithmetic shift model.
module tb_shu_pipe;
  localparam int N = 32;
  localparam int K = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shu_pipe_if #(.N(N)) bus ();

  shu_pipe #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  logic [N-1:0] exp_q[$];
  int pop_cyc_q[$];
  bit rand_bp = 1'b0;
  logic ready_force = 1'b1;
  logic [N-1:0] held_r;
  bit held = 1'b0;

  always @(posedge clk) cyc++;

  // ---------------- clock/reset-side helpers ----------------
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] model(input logic [N-1:0] a, input int b, input logic [1:0] op);
    logic [N-1:0] res;
    case (op)
      2'b00: res = a << b;
      2'b01: res = a >> b;
      2'b10: res = $signed(a) >>> b;
`ifdef SHU_ROTATE_EN
      default: res = (b == 0) ? a : ((a >> b) | (a << (N - b)));
`else
      default: res = a << b;
`endif
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that took the request.
  task automatic send(input logic [N-1:0] a, input logic [K-1:0] b, input logic [1:0] op,
                      input logic [N-1:0] exp, output int waited);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles, required 1", waited);
    end else begin
      exp_q.push_back(exp);
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_outstanding", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [N-1:0] e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_out_valid", bus.out_valid, 1);
        check("hold_r", bus.r, held_r);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got r=%h with no request outstanding, required no output", bus.r);
        end else begin
          e = exp_q.pop_front();
          check("result", bus.r, e);
        end
        pop_cyc_q.push_back(cyc);
      end
      held = bus.out_valid && !bus.out_ready;
      held_r = bus.r;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    logic [N-1:0] ra;
    logic [K-1:0] rb;
    logic [1:0] rop;

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_r", bus.r, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // basic left shift and its latency
    send(32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002, w);
    idle();
    drain();
    check("latency", pop_cyc_q[$] - last_acc_cyc, 2);

    // directed right shifts and boundaries
    send(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, w);
    send(32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, w);
    send(32'h7FFF_FFF0, 5'd4,  2'b10, 32'h07FF_FFFF, w);
    send(32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF, w);
    send(32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, w);
    send(32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, w);
    for (int op = 0; op < 4; op++) begin
      ra = $urandom();
      send(ra, 5'd0, op[1:0], ra, w);
    end
    idle();
    drain();

    // streaming: back-to-back, in_ready must never drop
    pop_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      ra = $urandom();
      rb = K'($urandom_range(0, N - 1));
      rop = 2'($urandom_range(0, 2));
      send(ra, rb, rop, model(ra, rb, rop), w);
      check("stream_in_ready_wait", w, 0);
    end
    idle();
    drain();
    check("stream_count", pop_cyc_q.size(), 4);
    for (int i = 1; i < 4; i++)
      check("stream_consecutive", pop_cyc_q[i] - pop_cyc_q[i-1], 1);

    // backpressure: two fill the pipe, the third must stall
    ready_force = 1'b0;
    wait_cycles(2);
    send(32'h0000_000F, 5'd4,  2'b00, 32'h0000_00F0, w);
    send(32'hF000_0000, 5'd28, 2'b01, 32'h0000_000F, w);
    bus.in_valid = 1'b1;
    bus.a = 32'h8000_0000;
    bus.b = 5'd1;
    bus.op = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_r_first", bus.r, 32'h0000_00F0);
    end
    ready_force = 1'b1;
    send(32'h8000_0000, 5'd1, 2'b10, 32'hC000_0000, w);
    idle();
    drain();

    // reset with both stages full
    ready_force = 1'b0;
    wait_cycles(2);
    send(32'h1234_5678, 5'd8, 2'b00, 32'h3456_7800, w);
    send(32'h1234_5678, 5'd8, 2'b01, 32'h0012_3456, w);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_r", bus.r, 0);
    exp_q.delete();
    wait_cycles(2);
    rst_n = 1'b1;
    ready_force = 1'b1;
    wait_cycles(5);
    check("midrst_no_stale", bus.out_valid, 0);

    // op = 11
`ifdef SHU_ROTATE_EN
    send(32'h0101_0101, 5'd31, 2'b11, 32'h0202_0202, w);
    send(32'h1234_5678, 5'd4,  2'b11, 32'h8123_4567, w);
    send(32'h8000_0001, 5'd1,  2'b11, 32'hC000_0000, w);
`else
    send(32'h0000_0001, 5'd1,  2'b11, 32'h0000_0002, w);
    send(32'h8000_0001, 5'd31, 2'b11, 32'h8000_0000, w);
`endif
    idle();
    drain();

    // randomised traffic with random backpressure and gaps
    rand_bp = 1'b1;
    repeat (300) begin
      ra = $urandom();
      rb = K'($urandom_range(0, N - 1));
      rop = 2'($urandom_range(0, 3));
      send(ra, rb, rop, model(ra, rb, rop), w);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        wait_cycles($urandom_range(1, 3));
      end
    end
    idle();
    ready_force = 1'b1;
    rand_bp = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/shu_pipe.md
Name: shu_pipe

Overview:
- Pipelined, non-cyclic shift unit for the MIPS EX path. It is the logical/arithmetic counterpart of the combinational cyclic rotator.
- Performs sll, srl and sra on an N-bit operand by a K-bit amount.
- Two register stages, with valid/ready handshakes on both input and output.
- Right shifts are done by bit-reversing, left-shifting, then reversing back, so only one left-shift datapath is built.

Parameters:
- N, 32, datapath width; power of two, at least 8.
- K, $clog2(N), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- a  input  N  operand.
- b  input  K  shift amount, unsigned.
- op  input  2  00 sll, 01 srl, 10 sra, 11 ror (see Optional Feature).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- r  output  N  result.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - s1_valid=0, s2_valid=0, out_valid=0, r=0.
  - in_ready=1 once rst_n=1.
  - All data registers are cleared to 0.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances when !s1_valid || stage 2 advances.
  - in_ready = stage-1 advance condition, combinational from internal valids and out_ready.
- Stage 1, registered on input transfer:
  - x = bitrev(a) if op is srl/sra, else a.
  - Fill bit f = a[N-1] for sra, 0 otherwise.
  - x shifted left by b[1:0], vacated LSBs filled with f.
  - Stored: x, b[K-1:2], op, f.
- Stage 2, registered on stage-1 advance:
  - Shift left by 4*b[K-1:2], fill f.
  - Reverse again for right ops.
  - Result stored in r.
- Latency:
  - Exactly 2 cycles from input transfer to out_valid with no backpressure.
  - Throughput 1 per cycle.
- Backpressure:
  - With out_ready=0 and both stages full, in_ready=0.
  - r and out_valid hold stable until transfer.
  - No request is lost or duplicated.
- Boundaries:
  - b=0 returns a unchanged for all ops.
  - b=N-1 is the maximum shift; sra yields all copies of a[N-1].
  - Amounts never exceed N-1 (K bits).
- Simultaneous output transfer and stage-1 advance in the same cycle is allowed: the pipeline moves as a whole.
- Reset mid-operation discards all in-flight requests; out_valid drops asynchronously.
- Ordering: results leave in acceptance order.

Optional Feature:
- Macro: SHU_ROTATE_EN.
- Defined:
  - op=11 is rotate right by b.
  - Stage 1 fills vacated bits with the wrapped-out bits; stage 2 likewise.
  - Rotate uses the same reverse trick, so that any future rotate-left reuse is free.
  - Latency is unchanged.
- Undefined:
  - op=11 is treated exactly as sll.
  - No rotate wrap logic is synthesised.

Test Plan:
- Basic left shift: sll a=0x00000001 b=1 -> r=0x00000002, out_valid exactly 2 cycles after acceptance.
- Arithmetic right shift: srl a=0x80000000 b=31 -> r=0x00000001; sra a=0x80000000 b=4 -> r=0xF8000000; sra a=0x7FFFFFF0 b=4 -> r=0x07FFFFFF.
- Streaming: four back-to-back requests with out_ready=1 -> four results on consecutive cycles, in order, with in_ready held at 1.
- Backpressure: issue three requests with out_ready=0 -> in_ready drops after the 2nd acceptance and r holds the first result; release out_ready -> all three results delivered in order, none lost.
- Reset mid-operation: assert rst_n=0 with both stages full -> out_valid=0 and r=0 immediately; after release, no stale result appears.
- Rotate, with SHU_ROTATE_EN: ror a=0x01010101 b=31 -> r=0x02020202. Without the macro, op=11 with a=0x00000001 b=1 -> r=0x00000002.
